// File: rtl/fifo_rd_packer_if.sv
// Bundle between the FIFO read side, the packer and the downstream word sink.
// Signals: rempty/rdata/rinc (FIFO read port), flush, m_valid/m_ready/m_data/
// m_keep/m_last (packed word stream), word_cnt (accepted-word counter).
interface fifo_rd_packer_if #(
   parameter int DSIZE = 8,
   parameter int PACK  = 4
);
   logic                    rempty;
   logic [DSIZE-1:0]        rdata;
   logic                    rinc;
   logic                    flush;
   logic                    m_valid;
   logic                    m_ready;
   logic [DSIZE*PACK-1:0]   m_data;
   logic [PACK-1:0]         m_keep;
   logic                    m_last;
   logic [15:0]             word_cnt;

   // packer side
   modport master (
      input  rempty, rdata, flush, m_ready,
      output rinc, m_valid, m_data, m_keep, m_last, word_cnt
   );

   // environment side: FIFO, flush source and word sink
   modport slave (
      output rempty, rdata, flush, m_ready,
      input  rinc, m_valid, m_data, m_keep, m_last, word_cnt
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// Purpose: pops DSIZE-bit lanes from a show-ahead FIFO and packs PACK of them
//          little-endian into one output word; flush emits a partial word.
// Latency: m_valid rises the cycle after the pop that fills the last lane.
// Backpressure: an occupied, stalled output register blocks only the pop that
//          would complete the next word; full throughput when m_ready stays 1.
// Ports: rclk, rrst (async active-high), bus = fifo_rd_packer_if.master.
module fifo_rd_packer #(
   parameter int DSIZE = 8,
   parameter int PACK  = 4
) (
   input logic                 rclk,
   input logic                 rrst,
   fifo_rd_packer_if.master    bus
);
   localparam int             IW       = $clog2(PACK);
   localparam logic [IW-1:0]  LAST_IDX = IW'(PACK - 1);

   // accumulator
   logic [DSIZE-1:0]        lane [PACK];
   logic [IW-1:0]           idx;
   logic                    pend;

   // output register
   logic                    out_valid;
   logic [DSIZE*PACK-1:0]   out_data;
   logic [PACK-1:0]         out_keep;
   logic                    out_last;
   logic [15:0]             cnt;

   logic                    out_free;
   logic                    xfer;
   logic                    pop;
   logic                    fill;
   logic                    emit_flush;
   logic                    flush_take;
   logic [DSIZE*PACK-1:0]   acc_word;
   logic [DSIZE*PACK-1:0]   full_word;
   logic [PACK-1:0]         flush_keep;

   assign out_free   = !out_valid || bus.m_ready;
   assign xfer       = out_valid && bus.m_ready;
   // only the pop that completes a word needs room in the output register
   assign pop        = !rrst && !bus.rempty && !pend &&
                       ((idx != LAST_IDX) || out_free);
   assign fill       = pop && (idx == LAST_IDX);
   assign emit_flush = pend && out_free;
   // A flush coinciding with the word-completing pop has nothing left to
   // emit: that pop already ships every lane.
   assign flush_take = bus.flush && !pend && ((idx != '0) || pop) && !fill;

   // Lanes at or above idx are always zero, so the accumulator image is
   // directly the zero-padded partial word.
   always_comb begin
      acc_word   = '0;
      flush_keep = '0;
      for (int i = 0; i < PACK; i++) begin
         acc_word[i*DSIZE +: DSIZE] = lane[i];
         flush_keep[i]              = (i < int'(idx));
      end
      full_word = acc_word;
      full_word[(PACK-1)*DSIZE +: DSIZE] = bus.rdata;
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         idx       <= '0;
         pend      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         cnt       <= '0;
         for (int i = 0; i < PACK; i++) lane[i] <= '0;
      end else begin
         if (xfer) cnt <= cnt + 16'd1;

         // fill and emit_flush are exclusive: pops are held off while pending
         if (fill) begin
            out_valid <= 1'b1;
            out_data  <= full_word;
            out_keep  <= '1;
            out_last  <= 1'b0;
         end else if (emit_flush) begin
            out_valid <= 1'b1;
            out_data  <= acc_word;
            out_keep  <= flush_keep;
            out_last  <= 1'b1;
         end else if (xfer) begin
            out_valid <= 1'b0;
         end

         if (fill || emit_flush) begin
            idx <= '0;
            for (int i = 0; i < PACK; i++) lane[i] <= '0;
         end else if (pop) begin
            lane[idx] <= bus.rdata;
            idx       <= idx + IW'(1);
         end

         if (emit_flush)      pend <= 1'b0;
         else if (flush_take) pend <= 1'b1;
      end
   end

   assign bus.rinc     = pop;
   assign bus.m_valid  = out_valid;
   assign bus.m_data   = out_data;
   assign bus.m_keep   = out_keep;
   assign bus.m_last   = out_last;
   assign bus.word_cnt = cnt;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer (DSIZE=8, PACK=4): FIFO model, scoreboard of
// expected words, monitor for transfers, pops and output stability.
module tb_fifo_rd_packer;
   localparam int DSIZE = 8;
   localparam int PACK  = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic rclk = 1'b0;
   logic rrst;
   always #5 rclk = ~rclk;

   fifo_rd_packer_if #(.DSIZE(DSIZE), .PACK(PACK)) bus ();

   fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
      .rclk (rclk),
      .rrst (rrst),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- FIFO model (main writes mem/wr_ptr, model owns rd_ptr)
   logic [7:0] mem [256];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       do_pop;

   always @(posedge rclk) begin
      do_pop = bus.rinc;
      #1;
      if (do_pop && rd_ptr != wr_ptr) rd_ptr++;
      bus.rempty = (rd_ptr == wr_ptr);
      bus.rdata  = mem[rd_ptr[7:0]];
   end

   // ---------------- monitor
   logic [31:0] obs_data [256];
   logic [3:0]  obs_keep [256];
   logic        obs_last [256];
   int          obs_cyc  [256];
   int          obs_wr = 0;
   int          pop_cyc  [256];
   int          pop_total = 0;
   int          cyc = 0;
   int          bad_rinc = 0;
   int          stab_err = 0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_data;
   logic [3:0]  prev_keep;
   logic        prev_last;

   always @(negedge rclk) begin
      if (rrst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && (bus.m_data !== prev_data || bus.m_keep !== prev_keep ||
                           bus.m_last !== prev_last || bus.m_valid !== 1'b1))
            stab_err++;
         if (bus.m_valid && bus.m_ready) begin
            obs_data[obs_wr] = bus.m_data;
            obs_keep[obs_wr] = bus.m_keep;
            obs_last[obs_wr] = bus.m_last;
            obs_cyc[obs_wr]  = cyc;
            obs_wr++;
         end
         prev_hold = bus.m_valid && !bus.m_ready;
         prev_data = bus.m_data;
         prev_keep = bus.m_keep;
         prev_last = bus.m_last;
      end
      if (bus.rinc === 1'b1) begin
         pop_cyc[pop_total] = cyc;
         pop_total++;
         if (bus.rempty !== 1'b0) bad_rinc++;
      end
      cyc++;
   end

   // ---------------- scoreboard model
   word_t      exp_q [$];
   logic [7:0] acc [$];
   int         obs_rd  = 0;
   int         exp_cnt = 0;

   task automatic push_byte(input logic [7:0] b);
      word_t w;
      mem[wr_ptr[7:0]] = b;
      wr_ptr++;
      acc.push_back(b);
      if (acc.size() == PACK) begin
         w = '0;
         for (int i = 0; i < PACK; i++) w.data[i*8 +: 8] = acc[i];
         w.keep = 4'hF;
         w.last = 1'b0;
         exp_q.push_back(w);
         acc.delete();
      end
   endtask

   task automatic model_flush();
      word_t w;
      if (acc.size() > 0) begin
         w = '0;
         for (int i = 0; i < acc.size(); i++) begin
            w.data[i*8 +: 8] = acc[i];
            w.keep[i]        = 1'b1;
         end
         w.last = 1'b1;
         exp_q.push_back(w);
         acc.delete();
      end
   endtask

   task automatic wait_words(input int n);
      int k;
      k = 0;
      while (obs_wr < obs_rd + n && k < 300) begin
         @(negedge rclk);
         k++;
      end
      if (obs_wr < obs_rd + n) check("word_timeout", obs_wr - obs_rd, n);
      @(negedge rclk);
      while (obs_rd < obs_wr) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", obs_data[obs_rd], 0);
         end else begin
            word_t e;
            e = exp_q.pop_front();
            check("m_data", obs_data[obs_rd], e.data);
            check("m_keep", obs_keep[obs_rd], e.keep);
            check("m_last", obs_last[obs_rd], e.last);
            exp_cnt++;
         end
         obs_rd++;
      end
   endtask

   task automatic wait_pops(input int target);
      int k;
      k = 0;
      while (pop_total < target && k < 300) begin
         @(negedge rclk);
         k++;
      end
      if (pop_total < target) check("pop_timeout", pop_total, target);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_valid"},  bus.m_valid,  0);
      check({tag, "_m_data"},   bus.m_data,   0);
      check({tag, "_m_keep"},   bus.m_keep,   0);
      check({tag, "_m_last"},   bus.m_last,   0);
      check({tag, "_rinc"},     bus.rinc,     0);
      check({tag, "_word_cnt"}, bus.word_cnt, 0);
   endtask

   int base;
   int nr;
   int nv;

   initial begin
      rrst        = 1'b1;
      bus.m_ready = 1'b0;
      bus.flush   = 1'b0;
      repeat (3) @(negedge rclk);
      check_reset_outputs("reset");
      rrst = 1'b0;
      repeat (2) @(negedge rclk);

      // four bytes -> one full word
      bus.m_ready = 1'b1;
      base = pop_total;
      for (int i = 1; i <= 4; i++) push_byte(8'(i));
      wait_words(1);
      check("t1_pops", pop_total - base, 4);
      check("t1_word_cnt", bus.word_cnt, exp_cnt);

      // sixteen bytes streamed, no bubbles
      base = pop_total;
      nr   = obs_rd;
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      wait_words(4);
      check("t2_pop_span", pop_cyc[base + 15] - pop_cyc[base], 15);
      check("t2_word_span", obs_cyc[nr + 3] - obs_cyc[nr], 12);
      check("t2_word_cnt", bus.word_cnt, exp_cnt);

      // stalled sink: first word held, three more bytes accumulate
      bus.m_ready = 1'b0;
      base = pop_total;
      for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
      repeat (20) @(negedge rclk);
      check("t3_pops_stalled", pop_total - base, 7);
      check("t3_valid_held", bus.m_valid, 1);
      check("t3_data_held", bus.m_data, 32'h13121110);
      check("t3_rinc_blocked", bus.rinc, 0);
      bus.m_ready = 1'b1;
      wait_words(2);
      check("t3_pops_total", pop_total - base, 8);
      check("t3_word_cnt", bus.word_cnt, exp_cnt);

      // partial word via flush
      base = pop_total;
      push_byte(8'hAA);
      push_byte(8'hBB);
      wait_pops(base + 2);
      @(negedge rclk);
      bus.flush = 1'b1;
      @(negedge rclk);
      bus.flush = 1'b0;
      model_flush();
      wait_words(1);

      // flush with empty accumulator
      bus.flush = 1'b1;
      @(negedge rclk);
      bus.flush = 1'b0;
      model_flush();
      repeat (10) @(negedge rclk);
      check("empty_flush_words", obs_wr - obs_rd, 0);

      // flush in the same cycle as a pop
      push_byte(8'hCC);
      @(negedge rclk);
      check("pop_with_flush", bus.rinc, 1);
      bus.flush = 1'b1;
      @(negedge rclk);
      bus.flush = 1'b0;
      model_flush();
      wait_words(1);
      check("t4_word_cnt", bus.word_cnt, exp_cnt);

      // FIFO empty throughout
      nr = 0;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge rclk);
         if (bus.rinc !== 1'b0)    nr++;
         if (bus.m_valid !== 1'b0) nv++;
      end
      check("t5_rinc_cycles", nr, 0);
      check("t5_valid_cycles", nv, 0);

      // reset with a word pending and two bytes accumulated
      bus.m_ready = 1'b0;
      base = pop_total;
      for (int i = 0; i < 6; i++) push_byte(8'h20 + 8'(i));
      wait_pops(base + 6);
      @(negedge rclk);
      check("t6_valid_before", bus.m_valid, 1);
      rrst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      acc.delete();
      exp_q.delete();
      exp_cnt = 0;
      repeat (2) @(negedge rclk);
      rrst        = 1'b0;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i));
      wait_words(1);
      check("t6_word_cnt", bus.word_cnt, exp_cnt);
      check("t6_fresh_data", obs_data[obs_rd - 1], 32'h33323130);

      check("exp_left", exp_q.size(), 0);
      check("rinc_while_empty", bad_rinc, 0);
      check("unstable_output", stab_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter DSIZE, default 8, FIFO byte-lane width in bits.
REQ-002 SHALL have parameter PACK, default 4, lanes per output word (2..8).
REQ-003 SHALL have port rclk  input  1  read-domain clock; all state changes on its rising edge.
REQ-004 SHALL have port rrst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rempty  input  1  FIFO empty flag from the FIFO read side.
REQ-006 SHALL have port rdata  input  DSIZE  FIFO show-ahead head data, valid whenever rempty=0.
REQ-007 SHALL have port rinc  output  1  FIFO pop strobe; pop occurs at the rising edge where rinc=1.
REQ-008 SHALL have port flush  input  1  request to emit the current partial word.
REQ-009 SHALL have port m_valid  output  1  output word valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts the word.
REQ-011 SHALL have port m_data  output  DSIZE*PACK  packed word; lane i at bits [i*DSIZE +: DSIZE].
REQ-012 SHALL have port m_keep  output  PACK  per-lane valid mask.
REQ-013 SHALL have port m_last  output  1  word was produced by a flush.
REQ-014 SHALL have port word_cnt  output  16  count of accepted output words.

Function
REQ-015 SHALL hold one accumulator (PACK lanes plus lane index 0..PACK-1) and one output register.
REQ-016 SHALL drive rinc=1 only when rempty=0, no flush is pending, and the pop does not need to complete a word while the output register is occupied without m_ready=1.
REQ-017 SHALL never assert rinc while rempty=1 or rrst=1.
REQ-018 SHALL, on a pop, write rdata into lane[index] and increment index; first popped byte lands in lane 0 (little-endian).
REQ-019 SHALL, on the pop that fills lane PACK-1, load the output register with all lanes including that rdata, set m_keep=all ones, m_last=0, clear the accumulator; m_valid rises the cycle after that pop edge.
REQ-020 SHALL treat a transfer as m_valid=1 and m_ready=1 at a rising edge; the output register may be reloaded on the same edge as a transfer (full throughput: one word per PACK cycles with no bubbles).
REQ-021 SHALL hold m_data, m_keep and m_last stable while m_valid=1 and m_ready=0.
REQ-022 SHALL register a flush pulse as pending when index>0 (or a pop occurs in the same cycle); flush with empty accumulator and no same-cycle pop SHALL be ignored.
REQ-023 SHALL include a byte popped in the same cycle as flush in the flushed word.
REQ-024 SHALL, while flush is pending and the output register is free (or transferring), load it with the filled lanes, m_keep bits set for lanes 0..index-1 only, unfilled lanes of m_data zero, m_last=1, then clear the accumulator and pending flag.
REQ-025 SHALL suppress pops while flush is pending.
REQ-026 SHALL increment word_cnt by one per transfer, wrapping from 16'hFFFF to 0.

Reset
REQ-027 SHALL, while rrst=1, force m_valid=0, m_data=0, m_keep=0, m_last=0, rinc=0, word_cnt=0, index=0, flush pending=0.
REQ-028 SHALL discard any partial accumulator and unaccepted output word on reset mid-operation; FIFO contents are unaffected.
REQ-029 SHALL resume normal operation on the first rising edge after rrst deasserts.

Verification
REQ-030 SHALL test: FIFO holds 01,02,03,04, m_ready=1 -> four rinc pulses, one word m_data=32'h04030201, m_keep=4'hF, m_last=0, word_cnt=1.
REQ-031 SHALL test: 16 bytes 00..0F, m_ready=1 -> words 32'h03020100 .. 32'h0F0E0D0C back-to-back, rinc high every cycle, word_cnt=4.
REQ-032 SHALL test: m_ready=0, 8 bytes available -> first word held stable, 3 more bytes accumulate, rinc stays 0 for byte 8 until m_ready=1.
REQ-033 SHALL test: bytes AA,BB then flush -> m_data=32'h0000BBAA, m_keep=4'h3, m_last=1; flush on empty accumulator -> no word.
REQ-034 SHALL test: rempty=1 throughout -> rinc never 1, m_valid stays 0.
REQ-035 SHALL test: rrst pulsed after 2 bytes popped and a word pending -> all outputs 0, next 4 bytes form a fresh word starting at lane 0.
